// File: rtl/cic_integrator_chain.sv
// Cascaded, pipelined CIC integrator section with time-multiplexed per-channel accumulators.
// A sample accepted at edge t is registered at stage 0, then integrated once per edge in stages 1..STAGES.
module cic_integrator_chain #(
  parameter int IN_WIDTH = 24,
  parameter int WIDTH    = 64,
  parameter int STAGES   = 5,
  parameter int CHANNELS = 2,
  parameter int CH_BITS  = 3
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                clear,
  input  logic                in_strobe,
  input  logic [CH_BITS-1:0]  in_chan,
  input  logic [IN_WIDTH-1:0] in_data,
  output logic                out_strobe,
  output logic [CH_BITS-1:0]  out_chan,
  output logic [WIDTH-1:0]    out_data
);

  function automatic logic [WIDTH-1:0] sign_extend(input logic [IN_WIDTH-1:0] x);
    return WIDTH'($signed(x));
  endfunction

  logic                accept_s;
  logic                valid_r [0:STAGES];
  logic [CH_BITS-1:0]  chan_r  [0:STAGES];
  logic [WIDTH-1:0]    data_r  [0:STAGES];
  logic [WIDTH-1:0]    acc_r   [1:STAGES][0:CHANNELS-1];
  logic [WIDTH-1:0]    sum_s   [1:STAGES];

  // Accept only strobed samples addressed to an existing channel.
  always_comb begin
    accept_s = in_strobe && ({1'b0, in_chan} < (CH_BITS+1)'(CHANNELS));
  end

  // Per stage: select the tagged channel's accumulator and add the incoming value (wraps modulo 2**WIDTH).
  always_comb begin : sum_calc
    logic [WIDTH-1:0] sel;
    sel = '0;
    for (int k = 1; k <= STAGES; k++) begin
      sel = '0;
      for (int c = 0; c < CHANNELS; c++) begin
        sel = (chan_r[k-1] == CH_BITS'(c)) ? acc_r[k][c] : sel;
      end
      sum_s[k] = sel + data_r[k-1];
    end
  end

  // Pipeline registers and accumulators; clear and reset both flush everything.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k <= STAGES; k++) begin
        valid_r[k] <= 1'b0;
        chan_r[k]  <= '0;
        data_r[k]  <= '0;
      end
      for (int k = 1; k <= STAGES; k++) begin
        for (int c = 0; c < CHANNELS; c++) begin
          acc_r[k][c] <= '0;
        end
      end
    end else if (clear) begin
      for (int k = 0; k <= STAGES; k++) begin
        valid_r[k] <= 1'b0;
        chan_r[k]  <= '0;
        data_r[k]  <= '0;
      end
      for (int k = 1; k <= STAGES; k++) begin
        for (int c = 0; c < CHANNELS; c++) begin
          acc_r[k][c] <= '0;
        end
      end
    end else begin
      valid_r[0] <= accept_s;
      if (accept_s) begin
        chan_r[0] <= in_chan;
        data_r[0] <= sign_extend(in_data);
      end
      // Data and tag only move with a valid sample so the final stage holds its output between strobes.
      for (int k = 1; k <= STAGES; k++) begin
        valid_r[k] <= valid_r[k-1];
        if (valid_r[k-1]) begin
          data_r[k] <= sum_s[k];
          chan_r[k] <= chan_r[k-1];
          for (int c = 0; c < CHANNELS; c++) begin
            if (chan_r[k-1] == CH_BITS'(c)) begin
              acc_r[k][c] <= sum_s[k];
            end
          end
        end
      end
    end
  end

  assign out_strobe = valid_r[STAGES];
  assign out_chan   = chan_r[STAGES];
  assign out_data   = data_r[STAGES];

endmodule
